// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int RX_DATA_W = 9;

  typedef struct packed {
    logic                 ferr;
    logic                 perr;
    logic [RX_DATA_W-1:0] data;
  } rx_word_t;

  // Mode 11 is reserved and behaves like no parity.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through synchronous FIFO
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign do_rd = rd_en && !empty;
  // A write into a full FIFO is accepted only when the head slot is freed in the same cycle.
  assign do_wr = wr_en && (!full || do_rd);

  // Empty presents zeros so the head word never shows stale contents.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampled UART receiver feeding an error-tagged FWFT FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int OSR        = 16
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic                              cfg_en,
  input  logic [DIV_W-1:0]                  cfg_baud_div,
  input  logic [3:0]                        cfg_data_bits,
  input  logic [1:0]                        cfg_parity,
  input  logic                              cfg_stop2,
  input  logic                              rx,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              rd_perr,
  output logic                              rd_ferr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              ovr_err,
  input  logic                              ovr_clr,
  output logic                              break_det,
  output logic                              busy
);
  localparam int SW = $clog2(OSR);
  localparam int WW = DATA_W + 2;
  localparam logic [SW-1:0] SAMP_MID = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] SAMP_END = SW'(OSR - 1);

  rx_state_e         state;
  rx_state_e         next_state;
  logic              rx_s1;
  logic              rx_s2;
  logic [DIV_W-1:0]  tick_cnt;
  logic [SW-1:0]     samp_cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] data_reg;
  logic              par_bit;
  logic              ferr_r;
  logic              brk_r;

  logic              tick;
  logic              samp;
  logic              start_det;
  logic              push;
  logic              push_ferr;
  logic              push_perr;
  logic              push_brk;
  logic              brk_now;
  logic              pop;
  logic              ovr_set;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WW-1:0]     push_word;
  logic [WW-1:0]     head_word;

  assign tick    = (state != RX_IDLE) && (tick_cnt == cfg_baud_div);
  assign samp    = tick && (samp_cnt == ((state == RX_START) ? SAMP_MID : SAMP_END));
  // par_bit stays 0 when parity is off, so it drops out of the break test.
  assign brk_now = (data_reg == '0) && !par_bit && !rx_s2;
  assign push_perr = par_enabled(cfg_parity) &&
                     (par_bit != ((^data_reg) ^ (cfg_parity == PAR_ODD)));
  assign push_word = {push_ferr, push_perr, data_reg};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= RX_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start_det  = 1'b0;
    push       = 1'b0;
    push_ferr  = ferr_r;
    push_brk   = brk_r;
    if (!cfg_en) begin
      next_state = RX_IDLE;
    end else begin
      unique case (state)
        RX_IDLE: begin
          if (!rx_s2) begin
            next_state = RX_START;
            start_det  = 1'b1;
          end
        end
        RX_START: begin
          if (samp) begin
            next_state = rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (samp && (bit_cnt + 4'd1 == cfg_data_bits)) begin
            next_state = par_enabled(cfg_parity) ? RX_PARITY : RX_STOP1;
          end
        end
        RX_PARITY: begin
          if (samp) begin
            next_state = RX_STOP1;
          end
        end
        RX_STOP1: begin
          if (samp) begin
            push_ferr = !rx_s2;
            push_brk  = brk_now;
            if (cfg_stop2) begin
              next_state = RX_STOP2;
            end else begin
              next_state = RX_IDLE;
              push       = 1'b1;
            end
          end
        end
        RX_STOP2: begin
          if (samp) begin
            push_ferr  = ferr_r | !rx_s2;
            next_state = RX_IDLE;
            push       = 1'b1;
          end
        end
        default: next_state = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      tick_cnt  <= '0;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      data_reg  <= '0;
      par_bit   <= 1'b0;
      ferr_r    <= 1'b0;
      brk_r     <= 1'b0;
      break_det <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;

      // Counters idle at zero so the first tick is phase-locked to the start edge.
      if (state == RX_IDLE || next_state == RX_IDLE) begin
        tick_cnt <= '0;
        samp_cnt <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (samp) begin
          samp_cnt <= '0;
        end else if (tick) begin
          samp_cnt <= samp_cnt + 1'b1;
        end
      end

      if (start_det) begin
        bit_cnt  <= '0;
        data_reg <= '0;
        par_bit  <= 1'b0;
        ferr_r   <= 1'b0;
        brk_r    <= 1'b0;
      end

      if (state == RX_DATA && samp) begin
        bit_cnt <= bit_cnt + 4'd1;
        for (int i = 0; i < DATA_W; i++) begin
          if (bit_cnt == 4'(i)) begin
            data_reg[i] <= rx_s2;
          end
        end
      end

      if (state == RX_PARITY && samp) begin
        par_bit <= rx_s2;
      end

      if (state == RX_STOP1 && samp) begin
        ferr_r <= push_ferr;
        brk_r  <= push_brk;
      end

      break_det <= push && push_brk;

      if (ovr_set) begin
        ovr_err <= 1'b1;
      end else if (ovr_clr) begin
        ovr_err <= 1'b0;
      end
    end
  end

  assign pop     = !fifo_empty && rd_ready;
  assign ovr_set = push && fifo_full && !pop;

  uart_sync_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (rd_ready),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign rd_valid = !fifo_empty;
  assign rd_data  = head_word[DATA_W-1:0];
  assign rd_perr  = head_word[DATA_W];
  assign rd_ferr  = head_word[DATA_W+1];
  assign busy     = (state != RX_IDLE);

endmodule
